cpu_trace_buffer: RTL and testbench

Parametrised, synthesizable execution-trace capture block for the control-unit/datapath processor. It records per-instruction commit records (PC, instruction word, register write-back, ALU status) into a circular buffer. Recording stops a programmable number of entries after a PC-match trigger. The captured window is then drained through a valid/ready read port, so the debug visibility previously available only in simulation also exists in hardware.

---
 rtl/cpu_trace_buffer.sv | 163 ++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture buffer: circular commit-record RAM, PC-match trigger with post-trigger window, show-ahead drain port.
// Optional macro TRACE_STATUS_EN keeps the 4-bit ALU status field in the RAM; otherwise rd_status reads as zero.
module cpu_trace_buffer #(
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32,
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    trig_en,
  input  logic [PC_W-1:0]         trig_pc,
  input  logic                    cap_valid,
  input  logic [PC_W-1:0]         cap_pc,
  input  logic [INSTR_W-1:0]      cap_instr,
  input  logic                    cap_wr_en,
  input  logic [REG_ADDR_W-1:0]   cap_wr_addr,
  input  logic [DATA_W-1:0]       cap_wr_data,
  input  logic [3:0]              cap_status,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [PC_W-1:0]         rd_pc,
  output logic [INSTR_W-1:0]      rd_instr,
  output logic                    rd_wr_en,
  output logic [REG_ADDR_W-1:0]   rd_wr_addr,
  output logic [DATA_W-1:0]       rd_wr_data,
  output logic [3:0]              rd_status,
  output logic [$clog2(DEPTH):0]  count,
  output logic [1:0]              state,
  output logic                    triggered,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   post_cnt_q;
  logic [CNT_W-1:0]   count_q;
  logic               triggered_q;
  logic               overflow_q;

  logic [PC_W-1:0]       mem_pc    [DEPTH];
  logic [INSTR_W-1:0]    mem_instr [DEPTH];
  logic                  mem_wr_en [DEPTH];
  logic [REG_ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0]     mem_data  [DEPTH];

  logic capture_s;
  logic readout_s;
  logic full_s;
  logic trig_hit_s;
  logic pop_s;

  assign readout_s  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign capture_s  = cap_valid && ((state_q == ST_ARMED) || (state_q == ST_POST));
  assign full_s     = (count_q == CNT_W'(DEPTH));
  assign trig_hit_s = capture_s && (state_q == ST_ARMED) && trig_en && (cap_pc == trig_pc);
  assign rd_valid   = readout_s && (count_q != '0);
  assign pop_s      = rd_valid && rd_ready;

  // RAM has no reset; only entries between the pointers are ever exposed.
  always_ff @(posedge clock) begin
    if (capture_s) begin
      mem_pc[wr_ptr_q]    <= cap_pc;
      mem_instr[wr_ptr_q] <= cap_instr;
      mem_wr_en[wr_ptr_q] <= cap_wr_en;
      mem_addr[wr_ptr_q]  <= cap_wr_addr;
      mem_data[wr_ptr_q]  <= cap_wr_data;
    end
  end

`ifdef TRACE_STATUS_EN
  logic [3:0] mem_status [DEPTH];

  always_ff @(posedge clock) begin
    if (capture_s) begin
      mem_status[wr_ptr_q] <= cap_status;
    end
  end

  assign rd_status = rd_valid ? mem_status[rd_ptr_q] : 4'b0000;
`else
  logic unused_status_s;
  assign unused_status_s = ^cap_status;
  assign rd_status       = 4'b0000;
`endif

  // Control FSM: a full buffer overwrites its oldest entry by dragging the read pointer along.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_cnt_q  <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_q     <= ST_ARMED;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
          end else if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_q - CNT_W'(1);
          end
        end
        ST_ARMED, ST_POST: begin
          if (capture_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (full_s) begin
              rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
              overflow_q <= 1'b1;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
            if (state_q == ST_POST) begin
              post_cnt_q <= post_cnt_q - PTR_W'(1);
              if (post_cnt_q == PTR_W'(1)) begin
                state_q <= ST_DONE;
              end
            end else if (trig_hit_s) begin
              triggered_q <= 1'b1;
              post_cnt_q  <= PTR_W'(POST_DEPTH);
              state_q     <= (POST_DEPTH == 0) ? ST_DONE : ST_POST;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_pc      = rd_valid ? mem_pc[rd_ptr_q]    : '0;
  assign rd_instr   = rd_valid ? mem_instr[rd_ptr_q] : '0;
  assign rd_wr_en   = rd_valid ? mem_wr_en[rd_ptr_q] : 1'b0;
  assign rd_wr_addr = rd_valid ? mem_addr[rd_ptr_q]  : '0;
  assign rd_wr_data = rd_valid ? mem_data[rd_ptr_q]  : '0;

  assign count     = count_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: two instances (DEPTH=16/POST=4 and DEPTH=8/POST=0) checked against a list-based trace model.
module tb_cpu_trace_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [3:0]  st;
  } entry_t;

  logic        clock, reset, arm, trig_en, cap_valid, cap_wr_en, rd_ready;
  logic [31:0] trig_pc, cap_pc, cap_instr;
  logic [4:0]  cap_wr_addr;
  logic [63:0] cap_wr_data;
  logic [3:0]  cap_status;

  logic        a_rv, a_we, a_trig, a_ovf, b_rv, b_we, b_trig, b_ovf;
  logic [31:0] a_pc, a_instr, b_pc, b_instr;
  logic [4:0]  a_wa, b_wa, a_count;
  logic [3:0]  b_count, a_st, b_st;
  logic [63:0] a_wd, b_wd;
  logic [1:0]  a_state, b_state;

  cpu_trace_buffer #(.DEPTH(16), .POST_DEPTH(4)) dut_a (
    .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_wr_en(cap_wr_en),
    .cap_wr_addr(cap_wr_addr), .cap_wr_data(cap_wr_data), .cap_status(cap_status),
    .rd_ready(rd_ready), .rd_valid(a_rv), .rd_pc(a_pc), .rd_instr(a_instr), .rd_wr_en(a_we),
    .rd_wr_addr(a_wa), .rd_wr_data(a_wd), .rd_status(a_st), .count(a_count),
    .state(a_state), .triggered(a_trig), .overflow(a_ovf));

  cpu_trace_buffer #(.DEPTH(8), .POST_DEPTH(0)) dut_b (
    .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_wr_en(cap_wr_en),
    .cap_wr_addr(cap_wr_addr), .cap_wr_data(cap_wr_data), .cap_status(cap_status),
    .rd_ready(rd_ready), .rd_valid(b_rv), .rd_pc(b_pc), .rd_instr(b_instr), .rd_wr_en(b_we),
    .rd_wr_addr(b_wa), .rd_wr_data(b_wd), .rd_status(b_st), .count(b_count),
    .state(b_state), .triggered(b_trig), .overflow(b_ovf));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: oldest-first list of entries per instance plus phase/flags.
  int     m_state [2];
  int     m_size  [2];
  int     m_pcnt  [2];
  bit     m_trig  [2];
  bit     m_ovf   [2];
  entry_t m_list  [2][16];
  int     m_depth [2] = '{16, 8};
  int     m_post  [2] = '{4, 0};

  task automatic model_drop_oldest(input int k);
    for (int i = 0; i < 15; i++) m_list[k][i] = m_list[k][i+1];
    m_size[k]--;
  endtask

  task automatic model_edge(input int k);
    entry_t e;
    if (!reset) begin
      m_state[k] = 0; m_size[k] = 0; m_pcnt[k] = 0; m_trig[k] = 1'b0; m_ovf[k] = 1'b0;
    end else if (m_state[k] == 0 || m_state[k] == 3) begin
      if (arm) begin
        m_state[k] = 1; m_size[k] = 0; m_trig[k] = 1'b0; m_ovf[k] = 1'b0;
      end else if (m_size[k] > 0 && rd_ready) begin
        model_drop_oldest(k);
      end
    end else if (cap_valid) begin
      e.pc = cap_pc; e.instr = cap_instr; e.we = cap_wr_en;
      e.wa = cap_wr_addr; e.wd = cap_wr_data; e.st = cap_status;
      if (m_size[k] == m_depth[k]) begin
        model_drop_oldest(k);
        m_ovf[k] = 1'b1;
      end
      m_list[k][m_size[k]] = e;
      m_size[k]++;
      if (m_state[k] == 1) begin
        if (trig_en && cap_pc == trig_pc) begin
          m_trig[k] = 1'b1;
          if (m_post[k] == 0) m_state[k] = 3;
          else begin m_state[k] = 2; m_pcnt[k] = m_post[k]; end
        end
      end else begin
        m_pcnt[k]--;
        if (m_pcnt[k] == 0) m_state[k] = 3;
      end
    end
  endtask

  function automatic logic [147:0] exp_v(input int k);
    entry_t h;
    logic   rv;
    rv = (m_state[k] == 0 || m_state[k] == 3) && (m_size[k] > 0);
    h  = rv ? m_list[k][0] : '0;
`ifndef TRACE_STATUS_EN
    h.st = 4'b0000;
`endif
    return {2'(m_state[k]), 5'(m_size[k]), m_trig[k], m_ovf[k], rv, h};
  endfunction

  function automatic logic [147:0] obs_a();
    return {a_state, a_count, a_trig, a_ovf, a_rv, a_pc, a_instr, a_we, a_wa, a_wd, a_st};
  endfunction

  function automatic logic [147:0] obs_b();
    return {b_state, 1'b0, b_count, b_trig, b_ovf, b_rv, b_pc, b_instr, b_we, b_wa, b_wd, b_st};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    cyc++;
  endtask

  task automatic drive_cap(input logic [31:0] pc);
    cap_valid   = 1'b1;
    cap_pc      = pc;
    cap_instr   = $urandom;
    cap_wr_en   = 1'($urandom_range(0, 1));
    cap_wr_addr = 5'($urandom);
    cap_wr_data = {$urandom, $urandom};
    cap_status  = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h0; trig_en = 1'b1; trig_pc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (obs_a() !== exp_v(0)) begin errors++; $display("FAIL reset_a cyc=%0d got=%h exp=%h", cyc, obs_a(), exp_v(0)); end
      if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL reset_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
    end
    checks++;
    if ({a_state, a_count, a_rv, a_trig, a_ovf} !== 10'd0) begin
      errors++; $display("FAIL reset_direct got=%b exp=0", {a_state, a_count, a_rv, a_trig, a_ovf});
    end
    reset = 1'b1; arm = 1'b0; cap_valid = 1'b0;
  endtask

  task automatic test_no_wrap();
    arm = 1'b1; tick(); arm = 1'b0;
    trig_en = 1'b1; trig_pc = 32'h10;
    for (int i = 0; i < 9; i++) begin
      drive_cap(32'(4 * i));
      tick();
      checks += 2;
      if (obs_a() !== exp_v(0)) begin errors++; $display("FAIL nowrap_cap_a cyc=%0d got=%h exp=%h", cyc, obs_a(), exp_v(0)); end
      if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL nowrap_cap_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
    end
    cap_valid = 1'b0;
    checks++;
    if ({a_state, a_count, a_trig, a_ovf} !== {2'd3, 5'd9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL nowrap_done got=%b exp=%b", {a_state, a_count, a_trig, a_ovf}, {2'd3, 5'd9, 1'b1, 1'b0});
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (a_pc !== 32'(4 * i)) begin errors++; $display("FAIL nowrap_order i=%0d got=%h exp=%h", i, a_pc, 32'(4 * i)); end
      tick();
      checks += 2;
      if (obs_a() !== exp_v(0)) begin errors++; $display("FAIL nowrap_rd_a cyc=%0d got=%h exp=%h", cyc, obs_a(), exp_v(0)); end
      if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL nowrap_rd_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_wrap_overflow();
    arm = 1'b1; tick(); arm = 1'b0;
    trig_pc = 32'h50;
    for (int i = 0; i < 25; i++) begin
      drive_cap(32'(4 * i));
      tick();
      checks += 2;
      if (obs_a() !== exp_v(0)) begin errors++; $display("FAIL wrap_cap_a cyc=%0d got=%h exp=%h", cyc, obs_a(), exp_v(0)); end
      if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL wrap_cap_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
    end
    cap_valid = 1'b0;
    checks++;
    if ({a_state, a_count, a_ovf, a_pc} !== {2'd3, 5'd16, 1'b1, 32'h24}) begin
      errors++; $display("FAIL wrap_done got=%h exp=%h", {a_state, a_count, a_ovf, a_pc}, {2'd3, 5'd16, 1'b1, 32'h24});
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        checks++;
        if (a_pc !== 32'h60) begin errors++; $display("FAIL wrap_last got=%h exp=60", a_pc); end
      end
      tick();
      checks += 2;
      if (obs_a() !== exp_v(0)) begin errors++; $display("FAIL wrap_rd_a cyc=%0d got=%h exp=%h", cyc, obs_a(), exp_v(0)); end
      if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL wrap_rd_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_post_zero();
    arm = 1'b1; tick(); arm = 1'b0;
    trig_pc = {20'h0, 10'($urandom), 2'b00};
    drive_cap(trig_pc);
    tick();
    checks++;
    if ({b_state, b_count, b_pc} !== {2'd3, 4'd1, trig_pc}) begin
      errors++; $display("FAIL post0_trigger got=%h exp=%h", {b_state, b_count, b_pc}, {2'd3, 4'd1, trig_pc});
    end
    drive_cap(trig_pc + 32'h4);
    tick();
    cap_valid = 1'b0;
    checks += 3;
    if (b_count !== 4'd1) begin errors++; $display("FAIL post0_nostore got=%0d exp=1", b_count); end
    if (obs_a() !== exp_v(0)) begin errors++; $display("FAIL post0_a cyc=%0d got=%h exp=%h", cyc, obs_a(), exp_v(0)); end
    if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL post0_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
  endtask

  task automatic test_handshake();
    logic [31:0] head_exp [4];
    logic        rdy_seq  [4];
    head_exp = '{32'hF0, 32'hF4, 32'hF4, 32'h100};
    rdy_seq  = '{1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b0; tick(); reset = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    trig_pc = 32'h100;
    drive_cap(32'hF0);  tick();
    drive_cap(32'hF4);  tick();
    drive_cap(32'h100); tick();
    cap_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_ready = rdy_seq[i];
      checks++;
      if (b_pc !== head_exp[i]) begin errors++; $display("FAIL hs_head i=%0d got=%h exp=%h", i, b_pc, head_exp[i]); end
      tick();
      checks++;
      if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL hs_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
    end
    checks++;
    if ({b_rv, b_count} !== 5'd0) begin errors++; $display("FAIL hs_empty got=%b exp=0", {b_rv, b_count}); end
    rd_ready = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    drive_cap(32'h100); tick(); cap_valid = 1'b0;
    arm = 1'b1; rd_ready = 1'b1; tick(); arm = 1'b0; rd_ready = 1'b0;
    checks++;
    if ({b_state, b_count} !== {2'd1, 4'd0}) begin
      errors++; $display("FAIL hs_arm_pop got=%b exp=%b", {b_state, b_count}, {2'd1, 4'd0});
    end
  endtask

  task automatic test_reset_post_status();
    logic [3:0] st_exp;
    reset = 1'b0; tick(); reset = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    trig_pc = 32'h200;
    drive_cap(32'h200); tick();
    drive_cap(32'h204); tick();
    cap_valid = 1'b0;
    checks++;
    if (a_state !== 2'd2) begin errors++; $display("FAIL midpost_state got=%0d exp=2", a_state); end
    reset = 1'b0; tick(); reset = 1'b1;
    checks++;
    if ({a_state, a_count} !== 7'd0) begin errors++; $display("FAIL midpost_reset got=%b exp=0", {a_state, a_count}); end
    arm = 1'b1; tick(); arm = 1'b0;
    drive_cap(32'h200); cap_status = 4'b1011; tick();
    cap_valid = 1'b0;
`ifdef TRACE_STATUS_EN
    st_exp = 4'b1011;
`else
    st_exp = 4'b0000;
`endif
    checks++;
    if ({b_count, b_st} !== {4'd1, st_exp}) begin
      errors++; $display("FAIL status got=%b exp=%b", {b_count, b_st}, {4'd1, st_exp});
    end
  endtask

  task automatic test_random();
    logic [31:0] pcs [4];
    pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      arm       = ($urandom_range(0, 15) == 0);
      trig_en   = ($urandom_range(0, 3) != 0);
      trig_pc   = pcs[$urandom_range(0, 3)];
      drive_cap(pcs[$urandom_range(0, 3)]);
      cap_valid = 1'($urandom_range(0, 1));
      rd_ready  = 1'($urandom_range(0, 1));
      tick();
      checks += 2;
      if (obs_a() !== exp_v(0)) begin errors++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc, obs_a(), exp_v(0)); end
      if (obs_b() !== exp_v(1)) begin errors++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_v(1)); end
    end
    reset = 1'b1; arm = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = 32'h0; cap_valid = 1'b0;
    cap_pc = 32'h0; cap_instr = 32'h0; cap_wr_en = 1'b0; cap_wr_addr = 5'h0;
    cap_wr_data = 64'h0; cap_status = 4'h0; rd_ready = 1'b0;
    #1;
    test_reset();
    test_no_wrap();
    test_wrap_overflow();
    test_post_zero();
    test_handshake();
    test_reset_post_status();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
